// File: rtl/r5p_ls_rsp.sv
// r5p load/store bus responder: byte-enabled word memory with a fixed
// number of wait states, registered read data and an out-of-range flag.
module r5p_ls_rsp #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = DW/8,
  parameter int unsigned SIZE   = 4096,
  parameter int unsigned WAIT   = 0,
  parameter bit          ERR_EN = 1'b1
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ls_vld,
  input  logic            ls_wen,
  input  logic [AW-1:0]   ls_adr,
  input  logic [BW-1:0]   ls_ben,
  input  logic [BW*8-1:0] ls_wdt,
  output logic [BW*8-1:0] ls_rdt,
  output logic            ls_rdy,
  output logic            ls_err
);

  localparam int unsigned MW    = $clog2(SIZE);
  localparam int unsigned LW    = $clog2(BW);
  localparam int unsigned DEPTH = SIZE/BW;
  localparam logic [3:0]  WAIT_C = 4'(WAIT);

  // Protocol state is a pure function of the wait counter and vld.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic                rdy_s;
  logic                hs_s;
  logic                oor_s;
  logic [MW-LW-1:0]    idx_s;
  logic                unused_s;
  logic [BW*8-1:0]     rdt_r;
  logic                err_r;
  logic [BW*8-1:0]     mem_r [DEPTH];

  // Byte offset bits are the initiator's business; upper bits only matter for range checking.
  assign idx_s    = ls_adr[MW-1:LW];
  assign oor_s    = ERR_EN & (|ls_adr[AW-1:MW]);
  assign unused_s = ^ls_adr[LW-1:0];

  // Decode the protocol state and the next wait-counter value.
  always_comb begin
    state_s   = ST_IDLE;
    cnt_nxt_s = 4'd0;
    if (!ls_vld) begin
      state_s = ST_IDLE;
    end else if (cnt_r == WAIT_C) begin
      state_s = ST_ACK;
    end else begin
      state_s = ST_WAIT;
    end
    case (state_s)
      ST_IDLE: cnt_nxt_s = 4'd0;
      ST_WAIT: cnt_nxt_s = cnt_r + 4'd1;
      ST_ACK:  cnt_nxt_s = 4'd0;
      default: cnt_nxt_s = 4'd0;
    endcase
  end

  // Ready is combinational from vld and forced low while reset is held.
  assign rdy_s  = rst_n & (state_s == ST_ACK);
  assign hs_s   = ls_vld & rdy_s;
  assign ls_rdy = rdy_s;

  // Wait counter register; dropping vld clears it, aborting the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Byte-lane memory write on an in-range write handshake; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BW); b++) begin
      if (hs_s & ls_wen & ~oor_s & ls_ben[b]) begin
        mem_r[idx_s][8*b +: 8] <= ls_wdt[8*b +: 8];
      end
    end
  end

  // Read data and error flag are registered, valid the cycle after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdt_r <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= hs_s & oor_s;
      if (hs_s & ~ls_wen) begin
        rdt_r <= oor_s ? '0 : mem_r[idx_s];
      end
    end
  end

  assign ls_rdt = rdt_r;
  assign ls_err = err_r;

endmodule

// File: tb/tb_r5p_ls_rsp.sv
// Directed bench for r5p_ls_rsp. Four instances cover WAIT=0, WAIT=2,
// WAIT=3 and WAIT=0 with range checking disabled.
module tb_r5p_ls_rsp;

  logic             clk;
  logic             rst_n;
  logic [3:0]       vld;
  logic [3:0]       wen;
  logic [3:0][31:0] adr;
  logic [3:0][3:0]  ben;
  logic [3:0][31:0] wdt;
  logic [3:0][31:0] rdt;
  logic [3:0]       rdy;
  logic [3:0]       err;

  int n_vec = 0;
  int n_err = 0;

  r5p_ls_rsp #(.WAIT(0), .ERR_EN(1'b1)) u_w0 (
    .clk(clk), .rst_n(rst_n), .ls_vld(vld[0]), .ls_wen(wen[0]), .ls_adr(adr[0]),
    .ls_ben(ben[0]), .ls_wdt(wdt[0]), .ls_rdt(rdt[0]), .ls_rdy(rdy[0]), .ls_err(err[0]));
  r5p_ls_rsp #(.WAIT(2), .ERR_EN(1'b1)) u_w2 (
    .clk(clk), .rst_n(rst_n), .ls_vld(vld[1]), .ls_wen(wen[1]), .ls_adr(adr[1]),
    .ls_ben(ben[1]), .ls_wdt(wdt[1]), .ls_rdt(rdt[1]), .ls_rdy(rdy[1]), .ls_err(err[1]));
  r5p_ls_rsp #(.WAIT(3), .ERR_EN(1'b1)) u_w3 (
    .clk(clk), .rst_n(rst_n), .ls_vld(vld[2]), .ls_wen(wen[2]), .ls_adr(adr[2]),
    .ls_ben(ben[2]), .ls_wdt(wdt[2]), .ls_rdt(rdt[2]), .ls_rdy(rdy[2]), .ls_err(err[2]));
  r5p_ls_rsp #(.WAIT(0), .ERR_EN(1'b0)) u_al (
    .clk(clk), .rst_n(rst_n), .ls_vld(vld[3]), .ls_wen(wen[3]), .ls_adr(adr[3]),
    .ls_ben(ben[3]), .ls_wdt(wdt[3]), .ls_rdt(rdt[3]), .ls_rdy(rdy[3]), .ls_err(err[3]));

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one request just after a falling edge, expect rdy only in
  // cycle nwait+1, return at the falling edge after the handshake with vld still high.
  task automatic xfer(input int i, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input int nwait,
                      input string tag);
    vld[i] = 1'b1; wen[i] = w; adr[i] = a; wdt[i] = d; ben[i] = b;
    for (int c = 0; c <= nwait; c++) begin
      #1;
      check_eq({tag, "_rdy"}, {31'd0, rdy[i]}, {31'd0, (c == nwait)});
      @(negedge clk);
    end
  endtask

  task automatic idle(input int i);
    vld[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    vld = '0; wen = '0; adr = '0; ben = '0; wdt = '0;
    #3;
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_rdt", rdt[i], 32'h0);
      check_eq("rst_rdy", {31'd0, rdy[i]}, 32'h0);
      check_eq("rst_err", {31'd0, err[i]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WAIT=0 full-word write then read, read data holds.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "w0_wr");
    check_eq("w0_wr_err", {31'd0, err[0]}, 32'h0);
    check_eq("w0_wr_rdt", rdt[0], 32'h0);
    idle(0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, "w0_rd");
    check_eq("w0_rd_rdt", rdt[0], 32'hDEADBEEF);
    idle(0);
    check_eq("w0_rd_hold", rdt[0], 32'hDEADBEEF);

    // ben=0 write is a no-op.
    xfer(0, 1'b1, 32'h10, 32'h0, 4'h0, 0, "w0_ben0");
    idle(0);
    xfer(0, 1'b0, 32'h13, 32'h0, 4'h1, 0, "w0_rd2");
    check_eq("w0_ben0_rdt", rdt[0], 32'hDEADBEEF);
    idle(0);

    // WAIT=2 byte-lane write.
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, "w2_wr");
    idle(1);
    xfer(1, 1'b1, 32'h10, 32'h000000AA, 4'h1, 2, "w2_bwr");
    idle(1);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 2, "w2_rd");
    check_eq("w2_rd_rdt", rdt[1], 32'hDEADBEAA);
    idle(1);

    // Back-to-back read/write/read on word 0, WAIT=0.
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, "bb_init");
    idle(0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, "bb_rd1");
    check_eq("bb_rd1_rdt", rdt[0], 32'hCAFEF00D);
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF, 0, "bb_wr");
    check_eq("bb_wr_rdt", rdt[0], 32'hCAFEF00D);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, "bb_rd2");
    check_eq("bb_rd2_rdt", rdt[0], 32'h11223344);
    idle(0);

    // Out-of-range write and read.
    xfer(0, 1'b1, 32'h1000, 32'h55, 4'hF, 0, "oor_wr");
    check_eq("oor_wr_err", {31'd0, err[0]}, 32'h1);
    idle(0);
    check_eq("oor_wr_err_end", {31'd0, err[0]}, 32'h0);
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, "oor_rd");
    check_eq("oor_rd_err", {31'd0, err[0]}, 32'h1);
    check_eq("oor_rd_rdt", rdt[0], 32'h0);
    idle(0);
    check_eq("oor_rd_err_end", {31'd0, err[0]}, 32'h0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, "oor_chk");
    check_eq("oor_chk_rdt", rdt[0], 32'h11223344);
    check_eq("oor_chk_err", {31'd0, err[0]}, 32'h0);
    idle(0);

    // WAIT=3 abort: vld dropped after two cycles leaves memory and counter clean.
    xfer(2, 1'b1, 32'h20, 32'h0, 4'hF, 3, "ab_init");
    idle(2);
    vld[2] = 1'b1; wen[2] = 1'b1; adr[2] = 32'h20; wdt[2] = 32'hFFFFFFFF; ben[2] = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("ab_rdy", {31'd0, rdy[2]}, 32'h0);
      @(negedge clk);
    end
    idle(2);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 3, "ab_rd");
    check_eq("ab_rd_rdt", rdt[2], 32'h0);
    idle(2);

    // Reset mid-wait on a pending write.
    xfer(2, 1'b1, 32'h24, 32'h5A5A5A5A, 4'hF, 3, "rs_init");
    idle(2);
    xfer(2, 1'b0, 32'h24, 32'h0, 4'hF, 3, "rs_rd");
    check_eq("rs_rd_rdt", rdt[2], 32'h5A5A5A5A);
    idle(2);
    vld[2] = 1'b1; wen[2] = 1'b1; adr[2] = 32'h24; wdt[2] = 32'hFFFFFFFF; ben[2] = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("rs_wait_rdy", {31'd0, rdy[2]}, 32'h0);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    vld[0] = 1'b1; wen[0] = 1'b0; adr[0] = 32'h0;
    #1;
    check_eq("rs_rdy", {31'd0, rdy[2]}, 32'h0);
    check_eq("rs_rdt", rdt[2], 32'h0);
    check_eq("rs_err", {31'd0, err[2]}, 32'h0);
    check_eq("rs_w0_rdy", {31'd0, rdy[0]}, 32'h0);
    check_eq("rs_w0_rdt", rdt[0], 32'h0);
    @(negedge clk);
    vld[0] = 1'b0;
    rst_n = 1'b1;
    xfer(2, 1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, 3, "rs_post");
    idle(2);
    xfer(2, 1'b0, 32'h24, 32'h0, 4'hF, 3, "rs_post_rd");
    check_eq("rs_post_rdt", rdt[2], 32'hFFFFFFFF);
    idle(2);

    // Aliasing with range checking disabled.
    xfer(3, 1'b1, 32'h1004, 32'h12345678, 4'hF, 0, "al_wr");
    check_eq("al_wr_err", {31'd0, err[3]}, 32'h0);
    idle(3);
    xfer(3, 1'b0, 32'h0004, 32'h0, 4'hF, 0, "al_rd");
    check_eq("al_rd_rdt", rdt[3], 32'h12345678);
    check_eq("al_rd_err", {31'd0, err[3]}, 32'h0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
